memory_responder: RTL and testbench
===================================

# memory_responder

Synthesizable memory-side responder for the `sel`/`wr_rd`/`ready` memory bus: the target an initiator drives through the memory interface clocking block. It accepts one read or write per request, inserts a programmable number of wait states, then pulses `ready` for exactly one cycle, returning `rdata` on reads. It serves as the DUT behind the memory UVM environment and as a reusable slave model in larger benches.

## Interface
- `data_width`, default 16: width of `wdata` and `rdata`.
- `addr_width`, default 8: address width. Depth is 2**addr_width words.
- `wait_states`, default 2: cycles spent in WAIT. Legal range is 0..15.

Ports:
- `clk` in 1: single clock. All logic is on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `addr` in addr_width: word address.
- `wdata` in data_width: write data.
- `sel` in 1: request valid. Held high by the initiator until `ready`.
- `wr_rd` in 1: 1 = write, 0 = read.
- `rdata` out data_width: read data. Valid while `ready`=1 on a read.
- `ready` out 1: one-cycle completion pulse.

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - If `sel`=1 at a posedge, capture `addr`, `wdata` and `wr_rd` into the request registers.
  - Load the wait counter with `wait_states`.
  - Go to WAIT, or go directly to RESP if `wait_states`=0.
- WAIT:
  - Decrement the counter each cycle. When the counter reaches 1, go to RESP on the next edge.
  - If `sel`=0 at any edge in WAIT, abort: return to IDLE with no write, no `ready` and `rdata` unchanged.
- Transition into RESP:
  - On a write, store the captured `wdata` at the captured `addr` on this same edge.
  - On a read, register array[captured addr] into `rdata` on this same edge.
- RESP:
  - `ready`=1 for exactly one cycle. Unconditionally go to IDLE.
  - `sel` is not sampled in RESP.
- `rdata` holds the last read value until the next read response. It is not cleared after `ready` falls.
- Input changes after capture are ignored. The captured request is authoritative.
- Storage is 2**addr_width words with a single port. It is not cleared by reset, so the contents of unwritten locations are unspecified.
- A read of an address written by an earlier completed transaction returns the new data.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, `ready`=0, `rdata`=0, counter=0, request registers=0. The array is untouched.
- Reset mid-transaction: the operation is dropped immediately. A pending write is not committed. `ready` stays 0.
- Latency from the edge N that samples `sel`=1 in IDLE:
  - `ready` is high between edge N+1+wait_states and the following edge.
  - With wait_states=0, `ready` is high after edge N+1.
- Back-to-back transactions:
  - The cycle after RESP is IDLE. If `sel` is still 1 there, a new request is captured at that edge.
  - Minimum spacing is therefore wait_states+2 cycles per transaction.
- Outputs are registered. There is no combinational path from inputs to `ready` or `rdata`.
- The initiator samples outputs through its clocking block skew, so the responder must not change outputs other than on posedge `clk`.

## Structure
- Package `memory_pkg` holds:
  - the `mem_state_e` enum (IDLE, WAIT, RESP), 2-bit encoding;
  - the default width constants `MEM_DATA_WIDTH`=16 and `MEM_ADDR_WIDTH`=8;
  - `MEM_MAX_WAIT`=15.
- Sub-module `mem_array`: parameterized storage with one synchronous write port and one synchronous read port (read registered into `rdata`), with no reset.
- `memory_responder` owns the FSM, the wait counter and the request capture registers.

## Test plan
- Reset: assert `rst`=0 mid-sim, then release → `ready`=0 and `rdata`=16'h0000. The first transaction after release completes normally.
- Write then read, wait_states=2:
  - Write addr 8'h3C, wdata 16'hA5A5 → `ready` pulse 3 cycles after `sel` is sampled.
  - Read addr 8'h3C → `rdata`=16'hA5A5 with `ready`.
- wait_states=0, back-to-back with `sel` held high:
  - Write 8'h00=16'h1111, then read 8'h00 → `ready` every 2 cycles, read returns 16'h1111.
- Abort: start a write to 8'h10 with 16'hBEEF, drop `sel` during WAIT → no `ready`. A later read of 8'h10 returns the prior value 16'h0001.
- Boundary addresses:
  - Write 8'hFF=16'hFFFF and 8'h00=16'h0000, then read both → exact values, no aliasing.
  - Change `addr` and `wdata` during WAIT → the captured values are used.
- Reset during WAIT of a write of 16'h5555 to 8'h20 → no `ready`. A later read of 8'h20 returns its pre-reset contents.

Source files
------------

// File: rtl/memory_responder_pkg.sv
// Shared types and default sizing for the memory responder and its storage.
// Wait-state count is a 4-bit quantity, so MEM_MAX_WAIT bounds the parameter.
package memory_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    localparam int MEM_DATA_WIDTH = 16;
    localparam int MEM_ADDR_WIDTH = 8;
    localparam int MEM_MAX_WAIT   = 15;

endpackage

// File: rtl/memory_responder_if.sv
// sel/wr_rd/ready memory bus; master is the initiator, slave is the responder.
// sel is held by the initiator until ready; ready is a single-cycle pulse.
interface memory_responder_if #(
    parameter int data_width = memory_pkg::MEM_DATA_WIDTH,
    parameter int addr_width = memory_pkg::MEM_ADDR_WIDTH
);
    logic [addr_width-1:0] addr;
    logic [data_width-1:0] wdata;
    logic                  sel;
    logic                  wr_rd;
    logic [data_width-1:0] rdata;
    logic                  ready;

    modport master (output addr, wdata, sel, wr_rd, input  rdata, ready);
    modport slave  (input  addr, wdata, sel, wr_rd, output rdata, ready);
endinterface

// File: rtl/memory_responder_mem_array.sv
// Single-port word storage: synchronous write, read registered on re_i, 1-cycle read latency.
// No reset anywhere, so contents survive a responder reset; no backpressure.
module mem_array
    import memory_pkg::*;
#(
    parameter int data_width = MEM_DATA_WIDTH,
    parameter int addr_width = MEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [addr_width-1:0] addr_i,
    input  logic [data_width-1:0] wdata_i,
    output logic [data_width-1:0] rdata_o
);

    localparam int DEPTH = 1 << addr_width;

    logic [data_width-1:0] mem_q [DEPTH];
    logic [data_width-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_responder.sv
// Memory-bus responder: captures a request, waits wait_states cycles, pulses ready once.
// ready rises wait_states+1 edges after sel is sampled; dropping sel during WAIT aborts.
module memory_responder
    import memory_pkg::*;
#(
    parameter int data_width  = MEM_DATA_WIDTH,
    parameter int addr_width  = MEM_ADDR_WIDTH,
    parameter int wait_states = 2
) (
    input logic               clk,
    input logic               rst,
    memory_responder_if.slave bus
);

    localparam int         WAIT_CLAMP = (wait_states > MEM_MAX_WAIT) ? MEM_MAX_WAIT : wait_states;
    localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_CLAMP);

    mem_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [data_width-1:0] wdata_q, wdata_d;
    logic                  wr_rd_q, wr_rd_d;
    logic                  ready_q, ready_d;
    logic                  rd_seen_q, rd_seen_d;

    logic                  mem_we;
    logic                  mem_re;
    logic [addr_width-1:0] mem_addr;
    logic [data_width-1:0] mem_wdata;
    logic [data_width-1:0] arr_rdata;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_rd_d   = wr_rd_q;
        // ready trails RESP by one edge so it is a pure register output.
        ready_d   = (state_q == RESP);
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (bus.sel) begin
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    wr_rd_d = bus.wr_rd;
                    cnt_d   = WAIT_LOAD;
                    if (WAIT_LOAD == 4'd0) begin
                        // Zero wait: the array access happens on the capture edge itself.
                        state_d   = RESP;
                        mem_addr  = bus.addr;
                        mem_wdata = bus.wdata;
                        mem_we    = bus.wr_rd;
                        mem_re    = !bus.wr_rd;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!bus.sel) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = RESP;
                        mem_we  = wr_rd_q;
                        mem_re  = !wr_rd_q;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rd_seen_d = rd_seen_q | mem_re;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_rd_q   <= 1'b0;
            ready_q   <= 1'b0;
            rd_seen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_rd_q   <= wr_rd_d;
            ready_q   <= ready_d;
            rd_seen_q <= rd_seen_d;
        end
    end

    mem_array #(
        .data_width (data_width),
        .addr_width (addr_width)
    ) u_mem_array (
        .clk     (clk),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (arr_rdata)
    );

    // The array read register has no reset; rdata reads as zero until the first read after reset.
    assign bus.rdata = rd_seen_q ? arr_rdata : '0;
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_memory_responder.sv
// Randomized bench for memory_responder: two instances (wait_states 2 and 0) against a transaction-level model.
module tb_memory_responder;

    logic clk;
    logic rst;

    logic        sel_s  [2];
    logic        wr_s   [2];
    logic [7:0]  addr_s [2];
    logic [15:0] wd_s   [2];

    int checks;
    int errors;

    int          ws_of [2];
    logic [15:0] mdl_mem [2][256];
    bit          mdl_vld [2][256];
    logic [15:0] mdl_rd [2];
    bit          mdl_rd_known [2];

    memory_responder_if #(.data_width(16), .addr_width(8)) bus0 ();
    memory_responder_if #(.data_width(16), .addr_width(8)) bus1 ();

    assign bus0.sel   = sel_s[0];
    assign bus0.wr_rd = wr_s[0];
    assign bus0.addr  = addr_s[0];
    assign bus0.wdata = wd_s[0];
    assign bus1.sel   = sel_s[1];
    assign bus1.wr_rd = wr_s[1];
    assign bus1.addr  = addr_s[1];
    assign bus1.wdata = wd_s[1];

    memory_responder #(.data_width(16), .addr_width(8), .wait_states(2)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    memory_responder #(.data_width(16), .addr_width(8), .wait_states(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic rdy(input int k);
        return (k == 0) ? bus0.ready : bus1.ready;
    endfunction

    function automatic logic [15:0] rd(input int k);
        return (k == 0) ? bus0.rdata : bus1.rdata;
    endfunction

    // mode: 0 normal, 1 scramble inputs after capture, 2 drop sel during WAIT
    task automatic txn(input int k, input bit wr, input logic [7:0] a, input logic [15:0] d, input int mode);
        int lat;
        lat = 0;
        sel_s[k]  = 1'b1;
        wr_s[k]   = wr;
        addr_s[k] = a;
        wd_s[k]   = d;
        @(posedge clk); #1;
        if (mode == 1) begin
            addr_s[k] = ~a;
            wd_s[k]   = ~d;
            wr_s[k]   = ~wr;
        end
        if (mode == 2) begin
            sel_s[k] = 1'b0;
            repeat (ws_of[k] + 3) begin
                @(posedge clk); #1;
                chk("abort_rdy", 32'(rdy(k)), 32'd0);
            end
            if (mdl_rd_known[k]) chk("abort_rdata", 32'(rd(k)), 32'(mdl_rd[k]));
            return;
        end
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (rdy(k)) begin
                lat = c;
                break;
            end
        end
        sel_s[k] = 1'b0;
        chk("latency", 32'(lat), 32'(ws_of[k] + 1));
        if (wr) begin
            mdl_mem[k][a] = d;
            mdl_vld[k][a] = 1'b1;
        end else begin
            mdl_rd[k]       = mdl_mem[k][a];
            mdl_rd_known[k] = mdl_vld[k][a];
        end
        if (mdl_rd_known[k]) chk(wr ? "rdata_hold" : "rdata", 32'(rd(k)), 32'(mdl_rd[k]));
        @(posedge clk); #1;
        chk("pulse_width", 32'(rdy(k)), 32'd0);
    endtask

    initial begin
        int k, pick, mode;
        bit wr;
        logic [7:0] a;
        logic [15:0] d;

        checks = 0;
        errors = 0;
        ws_of[0] = 2;
        ws_of[1] = 0;
        for (int i = 0; i < 2; i++) begin
            sel_s[i]  = 1'b0;
            wr_s[i]   = 1'b0;
            addr_s[i] = '0;
            wd_s[i]   = '0;
            mdl_rd[i] = '0;
            mdl_rd_known[i] = 1'b1;
            for (int j = 0; j < 256; j++) mdl_vld[i][j] = 1'b0;
        end

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready0", 32'(rdy(0)), 32'd0);
        chk("rst_rdata0", 32'(rd(0)), 32'd0);
        chk("rst_ready1", 32'(rdy(1)), 32'd0);
        chk("rst_rdata1", 32'(rd(1)), 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Write then read with two wait states
        txn(0, 1'b1, 8'h3C, 16'hA5A5, 0);
        txn(0, 1'b0, 8'h3C, 16'h0000, 0);

        // Zero wait states, back-to-back with sel held
        sel_s[1] = 1'b1; wr_s[1] = 1'b1; addr_s[1] = 8'h00; wd_s[1] = 16'h1111;
        @(posedge clk); #1;
        chk("b2b_idle", 32'(rdy(1)), 32'd0);
        @(posedge clk); #1;
        chk("b2b_wr_ready", 32'(rdy(1)), 32'd1);
        wr_s[1] = 1'b0;
        @(posedge clk); #1;
        chk("b2b_gap", 32'(rdy(1)), 32'd0);
        @(posedge clk); #1;
        chk("b2b_rd_ready", 32'(rdy(1)), 32'd1);
        chk("b2b_rdata", 32'(rd(1)), 32'h1111);
        sel_s[1] = 1'b0;
        mdl_mem[1][8'h00] = 16'h1111;
        mdl_vld[1][8'h00] = 1'b1;
        mdl_rd[1] = 16'h1111;
        mdl_rd_known[1] = 1'b1;
        @(posedge clk); #1;
        chk("b2b_pulse_width", 32'(rdy(1)), 32'd0);

        // Abort during WAIT leaves the prior contents
        txn(0, 1'b1, 8'h10, 16'h0001, 0);
        txn(0, 1'b1, 8'h10, 16'hBEEF, 2);
        txn(0, 1'b0, 8'h10, 16'h0000, 0);

        // Boundary addresses, no aliasing
        txn(0, 1'b1, 8'hFF, 16'hFFFF, 0);
        txn(0, 1'b1, 8'h00, 16'h0000, 0);
        txn(0, 1'b0, 8'hFF, 16'h0000, 0);
        txn(0, 1'b0, 8'h00, 16'h0000, 0);

        // Inputs changed during WAIT are ignored
        txn(0, 1'b1, 8'hBE, 16'h4321, 0);
        txn(0, 1'b1, 8'h41, 16'h1234, 1);
        txn(0, 1'b0, 8'h41, 16'h0000, 0);
        txn(0, 1'b0, 8'hBE, 16'h0000, 0);

        // Reset during WAIT of a write drops it
        txn(0, 1'b1, 8'h20, 16'h7777, 0);
        sel_s[0] = 1'b1; wr_s[0] = 1'b1; addr_s[0] = 8'h20; wd_s[0] = 16'h5555;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_ready", 32'(rdy(0)), 32'd0);
        chk("midrst_rdata", 32'(rd(0)), 32'd0);
        for (int i = 0; i < 2; i++) begin
            mdl_rd[i] = '0;
            mdl_rd_known[i] = 1'b1;
        end
        sel_s[0] = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("midrst_no_ready", 32'(rdy(0)), 32'd0);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        txn(0, 1'b0, 8'h20, 16'h0000, 0);

        // Randomized traffic on both instances
        for (int i = 0; i < 80; i++) begin
            k    = int'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            pick = int'($urandom_range(0, 11));
            a    = (pick == 10) ? 8'hFF : (pick == 11) ? 8'h80 : 8'(pick);
            d    = 16'($urandom);
            mode = 0;
            if (k == 0) begin
                pick = int'($urandom_range(0, 9));
                if (pick == 0) mode = 2;
                else if (pick == 1) mode = 1;
            end
            txn(k, wr, a, d, mode);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
